// File: rtl/divisor_sequencial.sv
// divisor_sequencial: 8-bit restoring shift-and-subtract divider, one
// quotient bit per clock. The iteration loop runs eight cycles, then one
// result-formation cycle registers the outputs as the FSM enters DONE.
// A zero divisor skips the loop and reports quotient 8'hFF, remainder =
// dividend and div_zero = 1.
// Optional feature: define DIVISOR_SIGNED_EN for two's-complement operands
// (magnitudes at capture, unsigned core, sign fix-up, -128 / -1 saturates
// to 8'h7F with overflow = 1). Without the macro, overflow is tied to 0 and
// no signed logic exists.
module divisor_sequencial (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dividendo,
    input  logic [7:0] divisor,
    output logic [7:0] quociente,
    output logic [7:0] resto,
    output logic       busy,
    output logic       done,
    output logic       div_zero,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;     // iteration counter
    logic       fin_q, fin_d;     // all eight quotient bits are in place
    logic [7:0] r_q, r_d;         // partial remainder R
    logic [7:0] q_q, q_d;         // dividend shifting out / quotient shifting in
    logic [7:0] d_q, d_d;         // divisor (magnitude)
    logic [7:0] a_q, a_d;         // raw dividend, returned on divide-by-zero
    logic [7:0] quo_q, quo_d;
    logic [7:0] rem_q, rem_d;
    logic       dz_q, dz_d;

    logic [8:0] trial;            // 9 bits so the borrow is never lost
    logic [7:0] a_mag, d_mag;
    logic [7:0] res_quo, res_rem;

`ifdef DIVISOR_SIGNED_EN
    logic qneg_q, qneg_d;         // operand signs differ
    logic rneg_q, rneg_d;         // dividend negative
    logic ovc_q, ovc_d;           // operands were -128 / -1
    logic ovf_q, ovf_d;
    logic res_ovf;

    assign a_mag = dividendo[7] ? -dividendo : dividendo;
    assign d_mag = divisor[7]   ? -divisor   : divisor;

    // Result formation: apply signs and saturate the one overflowing case
    always_comb begin
        res_ovf = 1'b0;
        res_quo = qneg_q ? -q_q : q_q;
        res_rem = rneg_q ? -r_q : r_q;
        if (ovc_q) begin
            res_quo = 8'h7F;
            res_rem = 8'h00;
            res_ovf = 1'b1;
        end
    end

    assign overflow = ovf_q;
`else
    assign a_mag    = dividendo;
    assign d_mag    = divisor;
    assign res_quo  = q_q;
    assign res_rem  = r_q;
    assign overflow = 1'b0;
`endif

    // Shifted remainder {R, Q[7]} minus the divisor
    assign trial = {r_q, q_q[7]} - {1'b0, d_q};

    // Next-state and datapath decode for the three-state controller
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        fin_d   = fin_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        a_d     = a_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
`ifdef DIVISOR_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        ovc_d   = ovc_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = dividendo;
                    d_d     = d_mag;
                    q_d     = a_mag;
                    r_d     = 8'd0;
                    cnt_d   = 3'd0;
                    fin_d   = 1'b0;
`ifdef DIVISOR_SIGNED_EN
                    qneg_d  = dividendo[7] ^ divisor[7];
                    rneg_d  = dividendo[7];
                    ovc_d   = (dividendo == 8'h80) && (divisor == 8'hFF);
`endif
                    state_d = CALC;
                end
            end
            CALC: begin
                cnt_d = cnt_q + 3'd1;
                if (d_q == 8'd0) begin
                    quo_d   = 8'hFF;
                    rem_d   = a_q;
                    dz_d    = 1'b1;
`ifdef DIVISOR_SIGNED_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = DONE;
                end else if (fin_q) begin
                    quo_d   = res_quo;
                    rem_d   = res_rem;
                    dz_d    = 1'b0;
`ifdef DIVISOR_SIGNED_EN
                    ovf_d   = res_ovf;
`endif
                    state_d = DONE;
                end else begin
                    if (!trial[8]) begin
                        r_d = trial[7:0];
                        q_d = {q_q[6:0], 1'b1};
                    end else begin
                        r_d = {r_q[6:0], q_q[7]};
                        q_d = {q_q[6:0], 1'b0};
                    end
                    if (cnt_q == 3'd7) begin
                        fin_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            fin_q   <= 1'b0;
            r_q     <= 8'd0;
            q_q     <= 8'd0;
            d_q     <= 8'd0;
            a_q     <= 8'd0;
            quo_q   <= 8'd0;
            rem_q   <= 8'd0;
            dz_q    <= 1'b0;
`ifdef DIVISOR_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            ovc_q   <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments make every register update from the pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            a_q     <= a_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
`ifdef DIVISOR_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            ovc_q   <= ovc_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign quociente = quo_q;
    assign resto     = rem_q;
    assign div_zero  = dz_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_divisor_sequencial.sv
// tb_divisor_sequencial: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction-level
// model (result from plain arithmetic, done edge = accept edge + 9, or + 1
// for a zero divisor). Build with DIVISOR_SIGNED_EN to exercise signed mode.
module tb_divisor_sequencial;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividendo;
    logic [7:0] divisor;
    logic [7:0] quociente;
    logic [7:0] resto;
    logic       busy;
    logic       done;
    logic       div_zero;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;      // count of clock edges seen out of reset

    // Transaction-level model state
    logic       m_active    = 1'b0;
    int         m_done_edge = 0;
    logic [7:0] m_q = 8'd0, m_r = 8'd0;
    logic       m_dz = 1'b0, m_ovf = 1'b0;
    logic [7:0] p_q, p_r;
    logic       p_dz, p_ovf;

    divisor_sequencial dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividendo (dividendo),
        .divisor   (divisor),
        .quociente (quociente),
        .resto     (resto),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference result straight from the arithmetic definition
    function automatic void model_div(input logic [7:0] a, input logic [7:0] b,
                                      output logic [7:0] q, output logic [7:0] r,
                                      output logic dz, output logic ov);
        int sa;
        int sb;
        sa = 0;
        sb = 0;
        dz = 1'b0;
        ov = 1'b0;
        q  = 8'd0;
        r  = 8'd0;
        if (b == 8'd0) begin
            q  = 8'hFF;
            r  = a;
            dz = 1'b1;
        end
`ifdef DIVISOR_SIGNED_EN
        else if (a == 8'h80 && b == 8'hFF) begin
            q  = 8'h7F;
            r  = 8'h00;
            ov = 1'b1;
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            q  = 8'(sa / sb);
            r  = 8'(sa % sb);
        end
`else
        else begin
            sa = int'(a);
            sb = int'(b);
            q  = 8'(sa / sb);
            r  = 8'(sa % sb);
        end
`endif
    endfunction

    // Model: accept when idle, publish results at the done edge, free one edge later
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_active = 1'b0;
                m_q      = 8'd0;
                m_r      = 8'd0;
                m_dz     = 1'b0;
                m_ovf    = 1'b0;
            end else begin
                cyc++;
                if (!m_active) begin
                    if (start) begin
                        m_active = 1'b1;
                        model_div(dividendo, divisor, p_q, p_r, p_dz, p_ovf);
                        m_done_edge = cyc + ((divisor == 8'd0) ? 1 : 9);
                    end
                end else if (cyc == m_done_edge) begin
                    m_q   = p_q;
                    m_r   = p_r;
                    m_dz  = p_dz;
                    m_ovf = p_ovf;
                end else if (cyc == m_done_edge + 1) begin
                    m_active = 1'b0;
                end
            end
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge clk) begin
        check("busy",      busy,      m_active);
        check("done",      done,      m_active && (cyc == m_done_edge));
        check("quociente", quociente, m_q);
        check("resto",     resto,     m_r);
        check("div_zero",  div_zero,  m_dz);
        check("overflow",  overflow,  m_ovf);
    end

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        check("idle wait", busy, 1'b0);
    endtask

    // One operation with hand-computed expectations; entered and left #1 after a rising edge
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic edz, input logic eov, input int elat,
                         input string tag);
        int k;
        int seen_at;
        logic seen;
        wait_idle();
        start     = 1'b1;
        dividendo = a;
        divisor   = b;
        @(posedge clk);
        #1;
        k       = cyc;
        start   = 1'b0;
        seen    = 1'b0;
        seen_at = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen    = 1'b1;
                seen_at = cyc;
            end
        end
        check({tag, " done seen"}, seen, 1'b1);
        check({tag, " latency"},   seen_at - k, elat);
        check({tag, " quociente"}, quociente, eq);
        check({tag, " resto"},     resto, er);
        check({tag, " div_zero"},  div_zero, edz);
        check({tag, " overflow"},  overflow, eov);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int ndone;
        int done_c;

        rst       = 1'b1;
        start     = 1'b0;
        dividendo = 8'd0;
        divisor   = 8'd0;
        #1;
        check("reset quociente", quociente, 8'd0);
        check("reset resto",     resto,     8'd0);
        check("reset busy",      busy,      1'b0);
        check("reset done",      done,      1'b0);
        check("reset div_zero",  div_zero,  1'b0);
        check("reset overflow",  overflow,  1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_op(8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 1'b0, 9, "100/7");
        do_op(8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 1'b0, 9, "255/1");
        do_op(8'd5,   8'd200, 8'd0,   8'd5,  1'b0, 1'b0, 9, "5/200");
        do_op(8'd13,  8'd0,   8'hFF,  8'd13, 1'b1, 1'b0, 1, "13/0");

        // Start pulses during CALC (cycle 3) and DONE (cycle 9) must be ignored
        wait_idle();
        start     = 1'b1;
        dividendo = 8'd100;
        divisor   = 8'd7;
        @(posedge clk);
        #1;
        k      = cyc;
        ndone  = 0;
        done_c = 0;
        for (int c = 0; c < 14; c++) begin
            start     = (c == 3 || c == 9);
            dividendo = 8'd9;
            divisor   = 8'd3;
            @(negedge clk);
            if (done) begin
                ndone++;
                done_c = cyc;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("overlap done count", ndone, 1);
        check("overlap latency",    done_c - k, 9);
        check("overlap quociente",  quociente, 8'd14);
        check("overlap resto",      resto, 8'd2);
        check("overlap busy after", busy, 1'b0);

        // Reset in CALC cycle 4 aborts the operation without a done pulse
        start     = 1'b1;
        dividendo = 8'd100;
        divisor   = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort quociente", quociente, 8'd0);
        check("abort resto",     resto,     8'd0);
        check("abort busy",      busy,      1'b0);
        check("abort done",      done,      1'b0);
        check("abort div_zero",  div_zero,  1'b0);
        check("abort overflow",  overflow,  1'b0);
        ndone = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) ndone++;
            @(posedge clk);
        end
        #1;
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
            @(posedge clk);
            #1;
        end
        check("abort no done", ndone, 0);
        do_op(8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 1'b0, 9, "50/5");

`ifdef DIVISOR_SIGNED_EN
        do_op(8'h9C, 8'd7,  8'hF2, 8'hFE, 1'b0, 1'b0, 9, "-100/7");
        do_op(8'h80, 8'hFF, 8'h7F, 8'h00, 1'b0, 1'b1, 9, "-128/-1");
        do_op(8'hF3, 8'd0,  8'hFF, 8'hF3, 1'b1, 1'b0, 1, "-13/0");
`endif

        // Random traffic: operands change every cycle, start held or pulsed, rare resets
        for (int n = 0; n < 3000; n++) begin
            start     = ($urandom_range(0, 3) == 0);
            dividendo = 8'($urandom);
            divisor   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
`ifdef DIVISOR_SIGNED_EN
            if ($urandom_range(0, 15) == 0) begin
                dividendo = 8'h80;
                divisor   = 8'hFF;
            end
`endif
            rst = ($urandom_range(0, 399) == 0);
            @(posedge clk);
            #1;
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
